// File: rtl/chess_pkg.sv
// Shared definitions for the move generator: piece encoding, square-code
// field positions, direction/knight tables, start and promotion rows.
package chess_pkg;

   typedef enum logic [2:0] {
      PT_NONE   = 3'd0,
      PT_PAWN   = 3'd1,
      PT_KNIGHT = 3'd2,
      PT_BISHOP = 3'd3,
      PT_ROOK   = 3'd4,
      PT_QUEEN  = 3'd5,
      PT_KING   = 3'd6
   } piece_t;

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_STEP, S_EMIT, S_DONE} state_t;

   // board[row][col], 5-bit square code
   typedef logic [7:0][7:0][4:0] board_t;

   localparam int OCC_BIT  = 0;
   localparam int CLR_BIT  = 1;
   localparam int TYPE_LSB = 2;
   localparam int TYPE_MSB = 4;

   // 0..3 orthogonal (N,S,W,E), 4..7 diagonal (NW,NE,SW,SE)
   localparam logic signed [4:0] DIR_DR [8] = '{-5'sd1, 5'sd1, 5'sd0, 5'sd0, -5'sd1, -5'sd1, 5'sd1, 5'sd1};
   localparam logic signed [4:0] DIR_DC [8] = '{5'sd0, 5'sd0, -5'sd1, 5'sd1, -5'sd1, 5'sd1, -5'sd1, 5'sd1};

   localparam logic signed [4:0] KN_DR [8] = '{-5'sd2, -5'sd2, -5'sd1, -5'sd1, 5'sd1, 5'sd1, 5'sd2, 5'sd2};
   localparam logic signed [4:0] KN_DC [8] = '{-5'sd1, 5'sd1, -5'sd2, 5'sd2, -5'sd2, 5'sd2, -5'sd1, 5'sd1};

   localparam logic [2:0] W_START_ROW = 3'd6;
   localparam logic [2:0] B_START_ROW = 3'd1;
   localparam logic [2:0] W_PROMO_ROW = 3'd0;
   localparam logic [2:0] B_PROMO_ROW = 3'd7;

   // Candidates (or rays, for sliders) a piece type walks through; 0 = not a piece
   function automatic logic [3:0] num_cand(input piece_t t);
      case (t)
         PT_PAWN, PT_BISHOP, PT_ROOK: return 4'd4;
         PT_KNIGHT, PT_QUEEN, PT_KING: return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

   // Unit direction component scaled by the ray distance
   function automatic logic signed [4:0] ray_off(input logic signed [4:0] d, input logic [3:0] n);
      logic signed [4:0] m;
      m = $signed({1'b0, n});
      if (d == 5'sd0) return 5'sd0;
      return d[4] ? -m : m;
   endfunction

endpackage

// File: rtl/move_gen_if.sv
// Move handshake bundle between the generator and its consumer.
interface move_gen_if;
   logic       move_valid;
   logic       move_ready;
   logic [5:0] move_from;
   logic [5:0] move_to;
   logic       move_capture;
   logic       move_promo;

   modport master (output move_valid, move_from, move_to, move_capture, move_promo,
                   input  move_ready);
   modport slave  (input  move_valid, move_from, move_to, move_capture, move_promo,
                   output move_ready);
endinterface

// File: rtl/sq_step.sv
// Offset a square by (dr,dc) and report what sits on the target.
module sq_step
   import chess_pkg::*;
(
   input  logic              [5:0] sq,
   input  logic signed       [4:0] dr,
   input  logic signed       [4:0] dc,
   input  board_t                  board,
   input  logic                    side,
   output logic                    onb,
   output logic              [5:0] tsq,
   output logic              [4:0] code,
   output logic                    empty,
   output logic                    opp
);
   logic signed [5:0] r, c;

   // target row/col; a non-zero upper part means off-board (no wrap)
   always_comb begin
      r     = $signed({3'b000, sq[5:3]}) + $signed({dr[4], dr});
      c     = $signed({3'b000, sq[2:0]}) + $signed({dc[4], dc});
      onb   = (r[5:3] == 3'b000) && (c[5:3] == 3'b000);
      tsq   = {r[2:0], c[2:0]};
      code  = onb ? board[r[2:0]][c[2:0]] : 5'd0;
      empty = onb && !code[OCC_BIT];
      opp   = onb && code[OCC_BIT] && (code[CLR_BIT] != side);
   end
endmodule

// File: rtl/move_gen.sv
// Pseudo-legal move enumerator: scans squares 0..63, steps each own piece
// through its candidate list and hands out one move per handshake.
// Optional feature macro: MOVEGEN_PROMO_EN (pawn promotion flag).
module move_gen
   import chess_pkg::*;
#(
   parameter int COUNT_W = 8
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               side,
   input  board_t             boardPos,
   output logic               busy,
   output logic               done,
   output logic [COUNT_W-1:0] move_count,
   move_gen_if.master         mv
);
   state_t state_q, state_d;
   board_t board_q, board_d;
   logic side_q, side_d, fin_q, fin_d, cap_q, cap_d;
   logic [5:0] sq_q, sq_d, from_q, from_d, to_q, to_d;
   logic [3:0] cand_q, cand_d, dist_q, dist_d;
   logic [COUNT_W-1:0] count_q, count_d;

   logic [4:0] own_code;
   piece_t ptype;
   logic is_own, slider, last_sq, last_cand, start_row, move_ok, ray_cont;
   logic [2:0] dir_idx;
   logic signed [4:0] fwd, dr, dc;
   logic t_onb, t_empty, t_opp, mid_empty;
   logic [5:0] t_sq;
   logic [4:0] t_code_unused, mid_code_unused;
   logic [5:0] mid_tsq_unused;
   logic mid_onb_unused, mid_opp_unused;

   // decode the piece under the scan pointer and pick the candidate offset
   always_comb begin
      own_code  = board_q[sq_q[5:3]][sq_q[2:0]];
      ptype     = piece_t'(own_code[TYPE_MSB:TYPE_LSB]);
      is_own    = own_code[OCC_BIT] && (own_code[CLR_BIT] == side_q) && (num_cand(ptype) != 4'd0);
      slider    = ptype inside {PT_BISHOP, PT_ROOK, PT_QUEEN};
      last_sq   = (sq_q == 6'd63);
      last_cand = (cand_q == num_cand(ptype) - 4'd1);
      start_row = (sq_q[5:3] == (side_q ? B_START_ROW : W_START_ROW));
      fwd       = side_q ? 5'sd1 : -5'sd1;
      // bishops use the diagonal half of the direction table
      dir_idx   = (ptype == PT_BISHOP) ? cand_q[2:0] + 3'd4 : cand_q[2:0];
      dr        = 5'sd0;
      dc        = 5'sd0;
      case (ptype)
         PT_PAWN: begin
            dr = (cand_q == 4'd1) ? (side_q ? 5'sd2 : -5'sd2) : fwd;
            if (cand_q == 4'd2)      dc = -5'sd1;
            else if (cand_q == 4'd3) dc = 5'sd1;
         end
         PT_KNIGHT: begin
            dr = KN_DR[cand_q[2:0]];
            dc = KN_DC[cand_q[2:0]];
         end
         PT_KING: begin
            dr = DIR_DR[dir_idx];
            dc = DIR_DC[dir_idx];
         end
         default: begin
            dr = ray_off(DIR_DR[dir_idx], dist_q);
            dc = ray_off(DIR_DC[dir_idx], dist_q);
         end
      endcase
   end

   sq_step u_tgt (
      .sq(sq_q), .dr(dr), .dc(dc), .board(board_q), .side(side_q),
      .onb(t_onb), .tsq(t_sq), .code(t_code_unused), .empty(t_empty), .opp(t_opp)
   );

   // square in front of a pawn, needed to qualify the double push
   sq_step u_mid (
      .sq(sq_q), .dr(fwd), .dc(5'sd0), .board(board_q), .side(side_q),
      .onb(mid_onb_unused), .tsq(mid_tsq_unused), .code(mid_code_unused),
      .empty(mid_empty), .opp(mid_opp_unused)
   );

   // judge the candidate; sliders keep walking while the target is empty
   always_comb begin
      move_ok = t_onb && (t_empty || t_opp);
      if (ptype == PT_PAWN) begin
         case (cand_q)
            4'd0:    move_ok = t_empty;
            4'd1:    move_ok = t_empty && mid_empty && start_row;
            default: move_ok = t_opp;
         endcase
      end
      ray_cont = slider && t_empty;
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_SCAN;
         S_SCAN: begin
            if (is_own)       state_d = S_STEP;
            else if (last_sq) state_d = S_DONE;
         end
         S_STEP: begin
            if (move_ok)                     state_d = S_EMIT;
            else if (!ray_cont && last_cand) state_d = last_sq ? S_DONE : S_SCAN;
         end
         S_EMIT: begin
            if (mv.move_ready) state_d = fin_q ? (last_sq ? S_DONE : S_SCAN) : S_STEP;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // outputs; busy is already low in the DONE cycle so it falls with done
   always_comb begin
      busy          = (state_q == S_SCAN) || (state_q == S_STEP) || (state_q == S_EMIT);
      done          = (state_q == S_DONE);
      mv.move_valid = (state_q == S_EMIT);
   end

   assign mv.move_from    = from_q;
   assign mv.move_to      = to_q;
   assign mv.move_capture = cap_q;
   assign move_count      = count_q;

   // datapath: snapshot, scan pointer, candidate cursor, move latch, counter
   always_comb begin
      board_d = board_q;
      side_d  = side_q;
      sq_d    = sq_q;
      cand_d  = cand_q;
      dist_d  = dist_q;
      fin_d   = fin_q;
      from_d  = from_q;
      to_d    = to_q;
      cap_d   = cap_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: if (start) begin
            board_d = boardPos;
            side_d  = side;
            sq_d    = 6'd0;
            cand_d  = 4'd0;
            dist_d  = 4'd1;
            count_d = '0;
         end
         S_SCAN: begin
            cand_d = 4'd0;
            dist_d = 4'd1;
            if (!is_own) sq_d = sq_q + 6'd1;
         end
         S_STEP: begin
            if (ray_cont) dist_d = dist_q + 4'd1;
            else begin
               cand_d = cand_q + 4'd1;
               dist_d = 4'd1;
            end
            fin_d = !ray_cont && last_cand;
            if (move_ok) begin
               from_d = sq_q;
               to_d   = t_sq;
               cap_d  = t_opp;
            end else if (!ray_cont && last_cand) begin
               sq_d = sq_q + 6'd1;
            end
         end
         S_EMIT: if (mv.move_ready) begin
            count_d = (count_q == '1) ? count_q : count_q + 1'b1;
            if (fin_q) sq_d = sq_q + 6'd1;
         end
         default: ;
      endcase
   end

   // datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         board_q <= '0;
         side_q  <= 1'b0;
         sq_q    <= 6'd0;
         cand_q  <= 4'd0;
         dist_q  <= 4'd1;
         fin_q   <= 1'b0;
         from_q  <= 6'd0;
         to_q    <= 6'd0;
         cap_q   <= 1'b0;
         count_q <= '0;
      end else begin
         board_q <= board_d;
         side_q  <= side_d;
         sq_q    <= sq_d;
         cand_q  <= cand_d;
         dist_q  <= dist_d;
         fin_q   <= fin_d;
         from_q  <= from_d;
         to_q    <= to_d;
         cap_q   <= cap_d;
         count_q <= count_d;
      end
   end

`ifdef MOVEGEN_PROMO_EN
   logic promo_q, promo_d;

   // promotion flag latched with the move
   always_comb begin
      promo_d = promo_q;
      if (state_q == S_STEP && move_ok)
         promo_d = (ptype == PT_PAWN) && (t_sq[5:3] == (side_q ? B_PROMO_ROW : W_PROMO_ROW));
   end

   // promotion flag register
   always_ff @(posedge clk) begin
      if (reset) promo_q <= 1'b0;
      else       promo_q <= promo_d;
   end

   assign mv.move_promo = promo_q;
`else
   assign mv.move_promo = 1'b0;
`endif

endmodule

// File: tb/tb_move_gen.sv
// Scoreboard bench for move_gen: a procedural reference enumerator fills the
// expected queue at start; moves are popped and compared as the DUT hands them out.
module tb_move_gen;
   typedef logic [7:0][7:0][4:0] brd_t;

   logic clk = 1'b0;
   logic reset, start, side, busy, done;
   brd_t boardPos;
   logic [7:0] move_count;

   move_gen_if mv();

   move_gen #(.COUNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .side(side), .boardPos(boardPos),
      .busy(busy), .done(done), .move_count(move_count), .mv(mv)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;
   int exp_cnt;
   logic [13:0] exp_q[$];
   logic [13:0] got_q[$];

   int KR[8] = '{-2, -2, -1, -1, 1, 1, 2, 2};
   int KC[8] = '{-1, 1, -2, 2, -2, 2, -1, 1};
   int DR[8] = '{-1, 1, 0, 0, -1, -1, 1, 1};
   int DC[8] = '{0, 0, -1, 1, -1, 1, -1, 1};

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic bit inb(int r, int c);
      return r >= 0 && r < 8 && c >= 0 && c < 8;
   endfunction

   function automatic bit emp(brd_t b, int r, int c);
      return inb(r, c) && !b[r[2:0]][c[2:0]][0];
   endfunction

   function automatic bit opp(brd_t b, int r, int c, logic sd);
      return inb(r, c) && b[r[2:0]][c[2:0]][0] && b[r[2:0]][c[2:0]][1] != sd;
   endfunction

   function automatic bit pro(int tr, logic sd);
`ifdef MOVEGEN_PROMO_EN
      return tr == (sd ? 7 : 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic void add(int r, int c, int tr, int tc, bit cap, bit pr);
      exp_q.push_back({6'(r * 8 + c), 6'(tr * 8 + tc), cap, pr});
   endfunction

   function automatic void model(brd_t b, logic sd);
      exp_q.delete();
      for (int s = 0; s < 64; s++) begin
         int r, c, f, lo, hi, tr, tc;
         logic [4:0] pc;
         r = s / 8; c = s % 8;
         pc = b[r[2:0]][c[2:0]];
         if (!pc[0] || pc[1] != sd) continue;
         case (pc[4:2])
            3'd1: begin
               f = sd ? 1 : -1;
               if (emp(b, r + f, c)) add(r, c, r + f, c, 0, pro(r + f, sd));
               if (r == (sd ? 1 : 6) && emp(b, r + f, c) && emp(b, r + 2 * f, c))
                  add(r, c, r + 2 * f, c, 0, pro(r + 2 * f, sd));
               if (opp(b, r + f, c - 1, sd)) add(r, c, r + f, c - 1, 1, pro(r + f, sd));
               if (opp(b, r + f, c + 1, sd)) add(r, c, r + f, c + 1, 1, pro(r + f, sd));
            end
            3'd2, 3'd6: for (int k = 0; k < 8; k++) begin
               tr = r + ((pc[4:2] == 3'd2) ? KR[k] : DR[k]);
               tc = c + ((pc[4:2] == 3'd2) ? KC[k] : DC[k]);
               if (emp(b, tr, tc) || opp(b, tr, tc, sd)) add(r, c, tr, tc, opp(b, tr, tc, sd), 0);
            end
            3'd3, 3'd4, 3'd5: begin
               lo = (pc[4:2] == 3'd3) ? 4 : 0;
               hi = (pc[4:2] == 3'd4) ? 3 : 7;
               for (int d = lo; d <= hi; d++) begin
                  for (int k = 1; k < 8; k++) begin
                     tr = r + k * DR[d]; tc = c + k * DC[d];
                     if (!(emp(b, tr, tc) || opp(b, tr, tc, sd))) break;
                     add(r, c, tr, tc, opp(b, tr, tc, sd), 0);
                     if (opp(b, tr, tc, sd)) break;
                  end
               end
            end
            default: ;
         endcase
      end
      exp_cnt = (exp_q.size() > 255) ? 255 : exp_q.size();
   endfunction

   function automatic brd_t init_board();
      brd_t b;
      int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
      b = '0;
      for (int c = 0; c < 8; c++) begin
         b[0][c] = {3'(back[c]), 2'b11};
         b[1][c] = 5'b00111;
         b[6][c] = 5'b00101;
         b[7][c] = {3'(back[c]), 2'b01};
      end
      return b;
   endfunction

   function automatic brd_t rnd_board();
      brd_t b;
      b = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            if ($urandom_range(3) == 0)
               b[r][c] = {3'($urandom_range(6, 1)), 1'($urandom_range(1)), 1'b1};
      return b;
   endfunction

   // One enumeration. hold: cycles to keep ready low on the first move;
   // rst_at: pulse reset when that move (1-based) is first presented.
   task automatic run(input brd_t b, input logic sd, input int rdy_pct, input int hold, input int rst_at);
      int cyc, seen;
      bit fin, pend;
      logic [13:0] cur, held, e;
      cyc = 0; seen = 0; fin = 0; pend = 0; held = '0;
      model(b, sd);
      got_q.delete();
      @(negedge clk);
      boardPos = b; side = sd; start = 1'b1; mv.move_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; side = ~sd; boardPos = rnd_board();
      chk("busy_after_start", busy, 1);
      while (!fin && cyc < 5000) begin
         cyc++;
         start = (cyc == 4);
         if (done) begin
            chk("count", move_count, exp_cnt);
            chk("busy_at_done", busy, 0);
            chk("moves_left", exp_q.size(), 0);
            fin = 1;
         end else begin
            if (mv.move_valid) begin
               cur = {mv.move_from, mv.move_to, mv.move_capture, mv.move_promo};
               if (pend) chk("held_stable", cur, held);
               else begin
                  seen++;
                  if (seen == rst_at) begin
                     reset = 1'b1; start = 1'b0;
                     @(negedge clk);
                     reset = 1'b0;
                     chk("rst_busy", busy, 0);
                     chk("rst_valid", mv.move_valid, 0);
                     chk("rst_count", move_count, 0);
                     exp_q.delete();
                     return;
                  end
               end
               if (hold > 0) begin
                  mv.move_ready = 1'b0;
                  hold--;
               end else mv.move_ready = ($urandom_range(99) < rdy_pct);
               if (mv.move_ready) begin
                  e = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h3fff;
                  chk("move", cur, e);
                  got_q.push_back(cur);
                  pend = 0;
               end else begin
                  pend = 1;
                  held = cur;
               end
            end else begin
               if (pend) chk("valid_held", mv.move_valid, 1);
               pend = 0;
               mv.move_ready = 1'($urandom_range(1));
            end
            @(negedge clk);
         end
      end
      if (!fin) chk("timeout_done", done, 1);
      start = 1'b0;
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("count_hold", move_count, exp_cnt);
   endtask

   initial begin
      brd_t ini, b;
      logic [13:0] m;
      int nc;
      reset = 1'b1; start = 1'b0; side = 1'b0; boardPos = '0; mv.move_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy0", busy, 0);
      chk("rst_done0", done, 0);
      chk("rst_valid0", mv.move_valid, 0);
      chk("rst_from0", mv.move_from, 0);
      chk("rst_to0", mv.move_to, 0);
      chk("rst_cap0", mv.move_capture, 0);
      chk("rst_promo0", mv.move_promo, 0);
      chk("rst_count0", move_count, 0);
      reset = 1'b0;

      ini = init_board();

      // white opening
      run(ini, 1'b0, 100, 0, 0);
      chk("w_moves", got_q.size(), 20);
      m = (got_q.size() > 0) ? got_q[0] : 14'h3fff;
      chk("w_first", m, {6'd48, 6'd40, 2'b00});
      m = (got_q.size() > 1) ? got_q[1] : 14'h3fff;
      chk("w_second", m, {6'd48, 6'd32, 2'b00});

      // black opening; the knight on square 1 is scanned before the pawn on 8
      run(ini, 1'b1, 100, 0, 0);
      chk("b_moves", got_q.size(), 20);
      m = 14'h3fff;
      foreach (got_q[i]) if (got_q[i][13:8] == 6'd8) begin m = got_q[i]; break; end
      chk("b_first_pawn8", m, {6'd8, 6'd16, 2'b00});

      // lone rook in the corner
      b = '0;
      b[0][0] = {3'd4, 2'b01};
      run(b, 1'b0, 70, 0, 0);
      chk("rook_moves", got_q.size(), 14);
      nc = 0;
      foreach (got_q[i]) nc += int'(got_q[i][1]);
      chk("rook_caps", nc, 0);

      // consumer stalls on the first move
      run(ini, 1'b0, 100, 5, 0);
      chk("stall_moves", got_q.size(), 20);

      // reset on the third move, then a clean run
      run(ini, 1'b0, 100, 0, 3);
      run(ini, 1'b0, 100, 0, 0);
      chk("post_rst_moves", got_q.size(), 20);

      // random positions with random back-pressure
      for (int i = 0; i < 6; i++) run(rnd_board(), 1'($urandom_range(1)), 60, 0, 0);

`ifdef MOVEGEN_PROMO_EN
      b = '0;
      b[1][0] = {3'd1, 2'b01};
      b[0][1] = {3'd4, 2'b11};
      run(b, 1'b0, 100, 0, 0);
      m = (got_q.size() > 0) ? got_q[0] : 14'h3fff;
      chk("promo_push", m, {6'd8, 6'd0, 1'b0, 1'b1});
      m = (got_q.size() > 1) ? got_q[1] : 14'h3fff;
      chk("promo_cap", m, {6'd8, 6'd1, 1'b1, 1'b1});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
